mp3_mem_arbiter: RTL
====================

Name: mp3_mem_arbiter

Overview:
- Shares one single-ported physical memory port between the pipeline's instruction-fetch side (I, read-only) and data side (D, read/write).
- Sits between the mp3 core's split I/D memory interfaces and a single magic or cached memory.
- Handshake is identical on both sides:
  - Requester holds read/write, address, wdata and wmask stable until a one-cycle resp.
  - rdata is valid in the cycle resp is high.
- Arbitration is round-robin on conflict. A grant is never revoked before mem_resp.

Parameters:
ADDR_WIDTH, 16, address width on all ports
DATA_WIDTH, 16, data width on all ports
MASK_WIDTH, 2, byte write-mask width (DATA_WIDTH/8)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_read  input  1  I-side read request
i_address  input  ADDR_WIDTH  I-side address
i_rdata  output  DATA_WIDTH  I-side read data
i_resp  output  1  I-side completion pulse
d_read  input  1  D-side read request
d_write  input  1  D-side write request (never together with d_read)
d_wmask  input  MASK_WIDTH  D-side byte enables
d_address  input  ADDR_WIDTH  D-side address
d_wdata  input  DATA_WIDTH  D-side write data
d_rdata  output  DATA_WIDTH  D-side read data
d_resp  output  1  D-side completion pulse
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_wmask  output  MASK_WIDTH  memory byte enables
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_resp  input  1  memory completion pulse
mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- States: IDLE, SERVE_I, SERVE_D. Register last_grant ∈ {I, D}.
- Reset: state=IDLE, last_grant=D (so the first tie goes to I).
- Output values while rst is high or in IDLE:
  - mem_read=0, mem_write=0.
  - mem_address=0, mem_wdata=0, mem_wmask=0.
  - i_resp=0, d_resp=0.
- i_rdata and d_rdata are always driven from mem_rdata. Only resp qualifies them.
- i_req = i_read. d_req = d_read | d_write.
- IDLE transitions:
  - Only i_req -> SERVE_I.
  - Only d_req -> SERVE_D.
  - Both -> serve the side not equal to last_grant.
  - Neither -> stay in IDLE.
  - Decision is registered: the memory sees the request the cycle after the requester asserts it. Minimum latency is 1 cycle plus memory latency.
- SERVE_I, combinational outputs:
  - mem_read=i_read, mem_write=0, mem_address=i_address.
  - mem_wmask=0, mem_wdata=0.
  - i_resp=mem_resp, d_resp=0.
- SERVE_D, combinational outputs:
  - mem_read=d_read, mem_write=d_write, mem_address=d_address.
  - mem_wmask=d_wmask, mem_wdata=d_wdata.
  - d_resp=mem_resp, i_resp=0.
- On mem_resp in SERVE_X:
  - last_grant<=X.
  - Next state is SERVE_other if the other side's request is high this cycle (back-to-back, no bubble); otherwise IDLE.
  - The same requester is never re-served directly. A new request from it passes through IDLE (1 bubble cycle).
- Without mem_resp: remain in SERVE_X. Grant is held even if the requester illegally drops its request; outputs then follow the requester's inputs.
- mem_resp in IDLE (for example, a late response after reset) is ignored. Neither i_resp nor d_resp pulses.
- rst asserted mid-transaction: IDLE on the next edge and the in-flight request is abandoned. Requesters must reissue.
- Guarantee: no starvation. With both sides continuously requesting, grants strictly alternate I, D, I, D.
- No combinational path from mem_resp to mem_read or mem_write.

Test Plan:
- Reset, then i_read=1, i_address=0x0010, memory latency 1: mem_read rises the cycle after i_read with mem_address=0x0010; i_resp pulses with i_rdata=mem_rdata (e.g. 0x1234); d_resp stays 0.
- D write d_write=1, d_address=0x0040, d_wdata=0xBEEF, d_wmask=2'b10: mem_write=1 with identical address, data and mask; d_resp pulses once; mem_read stays 0 throughout.
- After reset, i_read and d_read asserted in the same cycle and held: I is served first. On i_resp the arbiter enters SERVE_D in the next cycle with no IDLE cycle. Sustained requests alternate I, D, I, D over 8 transactions.
- Only I requests back-to-back (reasserts the cycle after i_resp): exactly one IDLE cycle between consecutive mem_read assertions; no d_resp.
- rst pulsed while in SERVE_D before mem_resp, then the memory asserts mem_resp one cycle later: all outputs are 0 during and after reset, and neither resp pulses.
- Memory latency of 5 cycles on a D read while i_read rises mid-transaction: the grant stays with D until mem_resp; i_resp never fires early; I is served immediately after d_resp.

Source files
------------

// File: rtl/mp3_mem_arbiter.sv
// mp3_mem_arbiter: shares one single-ported memory between the I-fetch side
// (read-only) and the D side (read/write). Round-robin on conflict; a grant
// is held until mem_resp and is never revoked early.
module mp3_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [MASK_WIDTH-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state, state_next;
  logic       last_grant, last_grant_next;
  logic       i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Read data is broadcast; only the resp pulse qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Next-state and round-robin bookkeeping.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          state_next = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
        else if (i_req)
          state_next = SERVE_I;
        else if (d_req)
          state_next = SERVE_D;
      end
      SERVE_I: begin
        if (mem_resp) begin
          last_grant_next = GRANT_I;
          state_next      = d_req ? SERVE_D : IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          last_grant_next = GRANT_D;
          state_next      = i_req ? SERVE_I : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Steer the granted side onto the memory port; everything is quiet in
  // IDLE and while reset is asserted, even before the state register clears.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    if (!rst) begin
      case (state)
        SERVE_I: begin
          mem_read    = i_read;
          mem_address = i_address;
          i_resp      = mem_resp;
        end
        SERVE_D: begin
          mem_read    = d_read;
          mem_write   = d_write;
          mem_address = d_address;
          mem_wdata   = d_wdata;
          mem_wmask   = d_wmask;
          d_resp      = mem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule
